// File: rtl/button_event_decoder.sv
// rtl/button_event_decoder.sv - debounced button level to press/release/long/repeat pulses
module button_event_decoder #(
  parameter int HOLD_TICKS   = 100,
  parameter int REPEAT_TICKS = 20,
  parameter int CNT_W        = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic pressed,
  output logic long_held
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    LONG  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_TICKS - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'((REPEAT_TICKS == 0) ? 0 : REPEAT_TICKS - 1);
  localparam logic             REPEAT_EN   = (REPEAT_TICKS != 0);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             lvl_q;
  logic             rise, fall;
  logic             press_nxt, release_nxt, long_nxt, repeat_nxt;

  assign rise = btn_level & ~lvl_q;
  assign fall = ~btn_level & lvl_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      lvl_q         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      pressed       <= 1'b0;
      long_held     <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      lvl_q         <= btn_level;
      press_pulse   <= press_nxt;
      release_pulse <= release_nxt;
      long_pulse    <= long_nxt;
      repeat_pulse  <= repeat_nxt;
      // Levels come from the next state so they move on the same edge as the pulse.
      pressed       <= (state_nxt != IDLE);
      long_held     <= (state_nxt == LONG);
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    long_nxt    = 1'b0;
    repeat_nxt  = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (rise) begin
          state_nxt = PRESS;
          press_nxt = 1'b1;
        end
      end
      PRESS: begin
        // A release wins over a coincident threshold tick.
        if (fall) begin
          state_nxt   = IDLE;
          cnt_nxt     = '0;
          release_nxt = 1'b1;
        end else if (tick) begin
          if (cnt == HOLD_LAST) begin
            state_nxt = LONG;
            cnt_nxt   = '0;
            long_nxt  = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      LONG: begin
        if (fall) begin
          state_nxt   = IDLE;
          cnt_nxt     = '0;
          release_nxt = 1'b1;
        end else if (REPEAT_EN && tick) begin
          if (cnt == REPEAT_LAST) begin
            cnt_nxt    = '0;
            repeat_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule
